rv_fan_thermal_ctrl: RTL and testbench

- Closed-loop thermal fan controller on the rv32 peripheral bus. Taps the sysmon conversion stream (eoc/channel/data), box-averages die-temperature samples and runs a 5-level hysteretic FSM that selects the fan PWM duty.
- Generates the fan PWM pin and a sticky over-temperature alarm. Software can force manual duty, read status and program thresholds.

---
 rtl/rv_fan_thermal_ctrl_if.sv | 34 +++
 rtl/rv_fan_thermal_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_rv_fan_thermal_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv_fan_thermal_ctrl_if.sv
// ---------------------------------------------------------------------------
// rv_fan_thermal_ctrl_if
// Register bus bundle for the thermal fan controller on the rv32
// peripheral bus.
//   adr : byte address (word index = adr[4:2])
//   cs  : chip select
//   rdy : bus ready / advance; writes and read captures happen only with rdy
//   we  : per-byte write enables
//   re  : read enable
//   dw  : write data
//   dr  : read data, valid the cycle after an accepted read
// The master drives the request side and the slave (the controller)
// returns dr.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface rv_fan_thermal_ctrl_if;
    logic [4:0]  adr;
    logic        cs;
    logic        rdy;
    logic [3:0]  we;
    logic        re;
    logic [31:0] dw;
    logic [31:0] dr;

    modport master (
        output adr, cs, rdy, we, re, dw,
        input  dr
    );

    modport slave (
        input  adr, cs, rdy, we, re, dw,
        output dr
    );
endinterface

// File: rtl/rv_fan_thermal_ctrl.sv
// ---------------------------------------------------------------------------
// rv_fan_thermal_ctrl
// Closed-loop fan controller. Die-temperature samples from the sysmon
// conversion stream are box-averaged in groups of four; each new average
// drives a 5-level hysteretic FSM (COOL/LOW/MID/HIGH/CRIT) that picks the
// fan PWM duty. Entering CRIT raises a sticky alarm that software clears.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   bus        : register bus (slave modport)
//   eoc_i      : sysmon end-of-conversion strobe
//   channel_i  : sysmon channel of the current conversion
//   ad_data_i  : sysmon conversion result
//   fan_out_o  : registered PWM fan drive
//   alarm_o    : sticky over-temperature alarm
// Register map (word offsets):
//   0x00 CTRL   [0] auto_en, [15:8] manual_duty
//   0x04 TH_LO[15:0], TH_MID[31:16]
//   0x08 TH_HI[15:0], TH_CRIT[31:16]
//   0x0C HYST[15:0]
//   0x10 STATUS [2:0] state, [3] alarm (write 1 clears), [15:8] duty,
//               [31:16] filtered temperature
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module rv_fan_thermal_ctrl #(
    parameter logic [5:0]  TEMP_CH     = 6'd0,
    parameter int          PRESCALE_W  = 16,
    parameter logic [15:0] TH_LO_RST   = 16'h9000,
    parameter logic [15:0] TH_MID_RST  = 16'hA000,
    parameter logic [15:0] TH_HI_RST   = 16'hB000,
    parameter logic [15:0] TH_CRIT_RST = 16'hC000,
    parameter logic [15:0] HYST_RST    = 16'h0400,
    parameter logic [7:0]  DUTY_COOL   = 8'h00,
    parameter logic [7:0]  DUTY_LOW    = 8'h40,
    parameter logic [7:0]  DUTY_MID    = 8'h80,
    parameter logic [7:0]  DUTY_HIGH   = 8'hC0,
    parameter logic [7:0]  DUTY_CRIT   = 8'hFF
) (
    input  logic                    clk,
    input  logic                    rst,
    rv_fan_thermal_ctrl_if.slave    bus,
    input  logic                    eoc_i,
    input  logic [5:0]              channel_i,
    input  logic [15:0]             ad_data_i,
    output logic                    fan_out_o,
    output logic                    alarm_o
);

    localparam logic [2:0] ST_COOL = 3'd0;
    localparam logic [2:0] ST_LOW  = 3'd1;
    localparam logic [2:0] ST_MID  = 3'd2;
    localparam logic [2:0] ST_HIGH = 3'd3;
    localparam logic [2:0] ST_CRIT = 3'd4;

    localparam logic [2:0] W_CTRL   = 3'd0;
    localparam logic [2:0] W_TH01   = 3'd1;
    localparam logic [2:0] W_TH23   = 3'd2;
    localparam logic [2:0] W_HYST   = 3'd3;
    localparam logic [2:0] W_STATUS = 3'd4;

    // Software-visible configuration
    logic        autoEn_q;
    logic [7:0]  manualDuty_q;
    logic [15:0] thLo_q;
    logic [15:0] thMid_q;
    logic [15:0] thHi_q;
    logic [15:0] thCrit_q;
    logic [15:0] hyst_q;

    // Read pipeline
    logic        re1_q;
    logic [2:0]  adr1_q;
    logic [31:0] rdData;

    // Filter
    logic [17:0] acc_q;
    logic [1:0]  cnt_q;
    logic [15:0] filt_q;
    logic        upd_q;
    logic [17:0] filtSum;
    logic        tempSample;

    // FSM and alarm
    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic [2:0]  target;
    logic [15:0] thrCur;
    logic [15:0] thrFloor;
    logic        alarm_q;
    logic        alarm_d;
    logic        alarmClr;

    // PWM
    logic [PRESCALE_W-1:0] presc_q;
    logic [7:0]  pwmCnt_q;
    logic        fanOut_q;
    logic [7:0]  stateDuty;
    logic [7:0]  activeDuty;

    logic        wrAcc;
    logic [2:0]  wrWord;
    logic        unusedOk;

    assign wrAcc      = bus.cs && bus.rdy;
    assign wrWord     = bus.adr[4:2];
    assign tempSample = eoc_i && (channel_i == TEMP_CH);
    assign filtSum    = acc_q + {2'b00, ad_data_i};
    assign alarmClr   = wrAcc && (wrWord == W_STATUS) && bus.we[0] && bus.dw[3];
    assign unusedOk   = ^{bus.adr[1:0], filtSum[1:0]};

    // Configuration registers. Each byte lane is written on its own, so a
    // narrow store only touches the bytes it enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            autoEn_q     <= 1'b1;
            manualDuty_q <= 8'h00;
            thLo_q       <= TH_LO_RST;
            thMid_q      <= TH_MID_RST;
            thHi_q       <= TH_HI_RST;
            thCrit_q     <= TH_CRIT_RST;
            hyst_q       <= HYST_RST;
        end else if (wrAcc) begin
            case (wrWord)
                W_CTRL: begin
                    if (bus.we[0]) autoEn_q     <= bus.dw[0];
                    if (bus.we[1]) manualDuty_q <= bus.dw[15:8];
                end
                W_TH01: begin
                    if (bus.we[0]) thLo_q[7:0]   <= bus.dw[7:0];
                    if (bus.we[1]) thLo_q[15:8]  <= bus.dw[15:8];
                    if (bus.we[2]) thMid_q[7:0]  <= bus.dw[23:16];
                    if (bus.we[3]) thMid_q[15:8] <= bus.dw[31:24];
                end
                W_TH23: begin
                    if (bus.we[0]) thHi_q[7:0]    <= bus.dw[7:0];
                    if (bus.we[1]) thHi_q[15:8]   <= bus.dw[15:8];
                    if (bus.we[2]) thCrit_q[7:0]  <= bus.dw[23:16];
                    if (bus.we[3]) thCrit_q[15:8] <= bus.dw[31:24];
                end
                W_HYST: begin
                    if (bus.we[0]) hyst_q[7:0]  <= bus.dw[7:0];
                    if (bus.we[1]) hyst_q[15:8] <= bus.dw[15:8];
                end
                default: ;
            endcase
        end
    end

    // Read request is registered on rdy; the data mux below then presents
    // the addressed word for the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re1_q  <= 1'b0;
            adr1_q <= 3'd0;
        end else if (bus.rdy) begin
            re1_q  <= bus.re;
            adr1_q <= bus.adr[4:2];
        end
    end

    // Read data mux; unmapped words return zero.
    always_comb begin
        rdData = 32'h0;
        case (adr1_q)
            W_CTRL:   rdData = {16'h0, manualDuty_q, 7'h0, autoEn_q};
            W_TH01:   rdData = {thMid_q, thLo_q};
            W_TH23:   rdData = {thCrit_q, thHi_q};
            W_HYST:   rdData = {16'h0, hyst_q};
            W_STATUS: rdData = {filt_q, activeDuty, 4'h0, alarm_q, state_q};
            default:  rdData = 32'h0;
        endcase
    end

    assign bus.dr = re1_q ? rdData : 32'h0;

    // Box filter over four temperature samples. The fourth sample is folded
    // in directly so the average covers exactly four values, and upd flags
    // the fresh result for the FSM on the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= 18'h0;
            cnt_q  <= 2'd0;
            filt_q <= 16'h0;
            upd_q  <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (tempSample) begin
                if (cnt_q == 2'd3) begin
                    filt_q <= filtSum[17:2];
                    acc_q  <= 18'h0;
                    cnt_q  <= 2'd0;
                    upd_q  <= 1'b1;
                end else begin
                    acc_q <= filtSum;
                    cnt_q <= cnt_q + 2'd1;
                end
            end
        end
    end

    // Target level is the highest threshold the filtered value has reached.
    always_comb begin
        target = ST_COOL;
        if (filt_q >= thCrit_q)     target = ST_CRIT;
        else if (filt_q >= thHi_q)  target = ST_HIGH;
        else if (filt_q >= thMid_q) target = ST_MID;
        else if (filt_q >= thLo_q)  target = ST_LOW;
    end

    // Next state: climb straight to the target, but descend one level at a
    // time and only once the value drops below the current threshold minus
    // the hysteresis. The floor clamps at zero so a large hysteresis can
    // never wrap around and force a spurious step down.
    always_comb begin
        thrCur  = 16'h0;
        state_d = state_q;
        case (state_q)
            ST_LOW:  thrCur = thLo_q;
            ST_MID:  thrCur = thMid_q;
            ST_HIGH: thrCur = thHi_q;
            ST_CRIT: thrCur = thCrit_q;
            default: thrCur = 16'h0;
        endcase
        thrFloor = (thrCur > hyst_q) ? (thrCur - hyst_q) : 16'h0;
        if (upd_q) begin
            if (target > state_q) begin
                state_d = target;
            end else if ((state_q != ST_COOL) && (filt_q < thrFloor)) begin
                state_d = state_q - 3'd1;
            end
        end
    end

    // Alarm latches on entry to CRIT; a simultaneous software clear loses.
    always_comb begin
        alarm_d = alarm_q;
        if (alarmClr) alarm_d = 1'b0;
        if ((state_d == ST_CRIT) && (state_q != ST_CRIT)) alarm_d = 1'b1;
    end

    // FSM and alarm state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COOL;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alarm_q <= alarm_d;
        end
    end

    // Duty per FSM level; manual mode overrides the output only, the FSM
    // keeps tracking temperature underneath.
    always_comb begin
        stateDuty = DUTY_COOL;
        case (state_q)
            ST_LOW:  stateDuty = DUTY_LOW;
            ST_MID:  stateDuty = DUTY_MID;
            ST_HIGH: stateDuty = DUTY_HIGH;
            ST_CRIT: stateDuty = DUTY_CRIT;
            default: stateDuty = DUTY_COOL;
        endcase
        activeDuty = autoEn_q ? stateDuty : manualDuty_q;
    end

    // PWM: the 8-bit step counter advances once per prescaler wrap, and the
    // compare is registered. Duty changes are picked up at the next compare
    // without restarting the period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= '0;
            pwmCnt_q <= 8'h00;
            fanOut_q <= 1'b0;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (presc_q == '0) pwmCnt_q <= pwmCnt_q + 8'd1;
            fanOut_q <= (pwmCnt_q < activeDuty);
        end
    end

    assign fan_out_o = fanOut_q;
    assign alarm_o   = alarm_q;

endmodule

// File: tb/tb_rv_fan_thermal_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv_fan_thermal_ctrl
// Self-checking bench for rv_fan_thermal_ctrl. Bus reads push their
// expected word onto a queue; a monitor pops and compares when dr becomes
// valid. The prescaler is shortened so a full PWM period is 1024 clocks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rv_fan_thermal_ctrl;

    localparam int PW        = 2;
    localparam int STEP_CLKS = 1 << PW;

    logic        clk = 1'b0;
    logic        rst;
    logic        eoc;
    logic [5:0]  channel;
    logic [15:0] adData;
    logic        fanOut;
    logic        alarm;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [31:0] expQ[$];
    string       tagQ[$];
    logic        readSeen = 1'b0;

    rv_fan_thermal_ctrl_if bus ();

    rv_fan_thermal_ctrl #(.PRESCALE_W(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .eoc_i     (eoc),
        .channel_i (channel),
        .ad_data_i (adData),
        .fan_out_o (fanOut),
        .alarm_o   (alarm)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] statusWord(input logic [15:0] filt,
                                               input logic [7:0] duty,
                                               input logic alm,
                                               input logic [2:0] st);
        return {filt, duty, 4'h0, alm, st};
    endfunction

    // Remember which edges accepted a read so the monitor knows when dr is due.
    always @(posedge clk) readSeen <= bus.cs && bus.re && bus.rdy && !rst;

    // Scoreboard monitor: dr is valid the cycle after an accepted read.
    always @(negedge clk) begin
        if (readSeen) begin
            if (expQ.size() == 0) begin
                checkOutput("read queue underflow", 32'd0, 32'd1);
            end else begin
                checkOutput(tagQ.pop_front(), bus.dr, expQ.pop_front());
            end
        end
    end

    // Drive one sysmon conversion.
    task automatic applyStimulus(input logic [5:0] ch, input logic [15:0] data);
        @(negedge clk);
        eoc     = 1'b1;
        channel = ch;
        adData  = data;
        @(negedge clk);
        eoc     = 1'b0;
    endtask

    task automatic feed4(input logic [15:0] data);
        repeat (4) applyStimulus(6'd0, data);
        repeat (3) @(negedge clk);
    endtask

    task automatic busWrite(input logic [4:0] addr, input logic [3:0] wen,
                            input logic [31:0] data);
        @(negedge clk);
        bus.cs  = 1'b1;
        bus.adr = addr;
        bus.we  = wen;
        bus.dw  = data;
        @(negedge clk);
        bus.cs  = 1'b0;
        bus.we  = 4'h0;
    endtask

    task automatic busRead(input string tag, input logic [4:0] addr,
                           input logic [31:0] expected);
        @(negedge clk);
        bus.cs  = 1'b1;
        bus.re  = 1'b1;
        bus.adr = addr;
        expQ.push_back(expected);
        tagQ.push_back(tag);
        @(negedge clk);
        bus.cs  = 1'b0;
        bus.re  = 1'b0;
    endtask

    // Count fan_out high clocks over one full PWM period.
    task automatic measurePwm(input string tag, input int dutySteps);
        int high = 0;
        repeat (256 * STEP_CLKS) begin
            @(negedge clk);
            if (fanOut) high++;
        end
        checkOutput(tag, high, dutySteps * STEP_CLKS);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst     = 1'b1;
        eoc     = 1'b0;
        channel = 6'd0;
        adData  = 16'h0;
        bus.adr = 5'h0;
        bus.cs  = 1'b0;
        bus.rdy = 1'b1;
        bus.we  = 4'h0;
        bus.re  = 1'b0;
        bus.dw  = 32'h0;

        repeat (3) @(negedge clk);
        checkOutput("reset dr", bus.dr, 32'h0);
        checkOutput("reset fan_out", {31'h0, fanOut}, 32'h0);
        checkOutput("reset alarm", {31'h0, alarm}, 32'h0);
        rst = 1'b0;

        busRead("reset TH01", 5'h04, 32'hA000_9000);
        busRead("reset TH23", 5'h08, 32'hC000_B000);
        busRead("reset HYST", 5'h0C, 32'h0000_0400);
        busRead("reset CTRL", 5'h00, 32'h0000_0001);
        busRead("reset STATUS", 5'h10, 32'h0);
        busRead("unmapped 0x1C", 5'h1C, 32'h0);
        measurePwm("pwm cool", 0);

        feed4(16'hA100);
        busRead("status MID", 5'h10, statusWord(16'hA100, 8'h80, 1'b0, 3'd2));
        measurePwm("pwm mid", 128);

        feed4(16'h9E00);
        busRead("status hyst hold", 5'h10, statusWord(16'h9E00, 8'h80, 1'b0, 3'd2));
        feed4(16'h9BFF);
        busRead("status step LOW", 5'h10, statusWord(16'h9BFF, 8'h40, 1'b0, 3'd1));

        feed4(16'h0000);
        busRead("status COOL", 5'h10, statusWord(16'h0000, 8'h00, 1'b0, 3'd0));
        feed4(16'hC800);
        busRead("status CRIT", 5'h10, statusWord(16'hC800, 8'hFF, 1'b1, 3'd4));
        checkOutput("alarm pin CRIT", {31'h0, alarm}, 32'h1);
        measurePwm("pwm crit", 255);
        feed4(16'h0000);
        busRead("status HIGH", 5'h10, statusWord(16'h0000, 8'hC0, 1'b1, 3'd3));
        checkOutput("alarm sticky", {31'h0, alarm}, 32'h1);
        busWrite(5'h10, 4'b0001, 32'h0000_0008);
        busRead("status alarm clr", 5'h10, statusWord(16'h0000, 8'hC0, 1'b0, 3'd3));
        checkOutput("alarm pin clr", {31'h0, alarm}, 32'h0);

        busWrite(5'h00, 4'b0011, 32'h0000_2000);
        busRead("CTRL manual", 5'h00, 32'h0000_2000);
        busRead("status manual", 5'h10, statusWord(16'h0000, 8'h20, 1'b0, 3'd3));
        measurePwm("pwm manual", 32);
        busWrite(5'h00, 4'b0011, 32'h0000_0001);

        applyStimulus(6'd0, 16'h1000);
        applyStimulus(6'd1, 16'hFFFF);
        applyStimulus(6'd0, 16'h2000);
        applyStimulus(6'd1, 16'hFFFF);
        applyStimulus(6'd0, 16'h3000);
        applyStimulus(6'd0, 16'h4000);
        repeat (3) @(negedge clk);
        busRead("status interleave", 5'h10, statusWord(16'h2800, 8'h80, 1'b0, 3'd2));

        applyStimulus(6'd0, 16'hF000);
        applyStimulus(6'd0, 16'hF000);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midrun reset fan", {31'h0, fanOut}, 32'h0);
        rst = 1'b0;
        busRead("status after reset", 5'h10, 32'h0);
        feed4(16'h8000);
        busRead("status fresh avg", 5'h10, statusWord(16'h8000, 8'h00, 1'b0, 3'd0));

        feed4(16'h9000);
        busRead("status at TH_LO", 5'h10, statusWord(16'h9000, 8'h40, 1'b0, 3'd1));
        busWrite(5'h0C, 4'b0011, 32'h0000_FFFF);
        busRead("HYST write", 5'h0C, 32'h0000_FFFF);
        feed4(16'h0000);
        busRead("status hyst sat", 5'h10, statusWord(16'h0000, 8'h40, 1'b0, 3'd1));

        busWrite(5'h08, 4'b0001, 32'h1234_5678);
        busRead("byte lane TH23", 5'h08, 32'hC000_B078);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
